// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and EX flush.
// Captures operands, immediate, PC, register numbers and packed control at
// the end of ID. A load in EX whose rd is read by the ID instruction stalls
// PC and IF/ID for one cycle and inserts a bubble into EX; a taken
// branch/jump resolved in EX flushes IF/ID and bubbles EX, overriding any
// stall.
// Optional feature: define PERF_CNT_EN to add stall_cnt/flush_cnt counters.
// Handshake: id_valid qualifies the ID slot; pc_write/ifid_write low means
// "upstream hold", ifid_flush high means "upstream discard". There is no
// backpressure from EX.
module id_ex_hazard_reg #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1Data,
   input  logic [XLEN-1:0]   id_rs2Data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_rs1Addr,
   input  logic [4:0]        id_rs2Addr,
   input  logic [4:0]        id_rdAddr,
   input  logic              id_useRs1,
   input  logic              id_useRs2,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              ex_flush,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1Data,
   output logic [XLEN-1:0]   ex_rs2Data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1Addr,
   output logic [4:0]        ex_rs2Addr,
   output logic [4:0]        ex_rdAddr,
   output logic [CTRL_W-1:0] ex_ctrl
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   // Bit 1 of the packed control word is MemRead.
   localparam int MEMREAD_BIT = 1;

   logic rs1_match;
   logic rs2_match;
   logic hz;

   // Load-use detection against the instruction currently held in EX.
   always_comb begin
      rs1_match  = id_useRs1 & (id_rs1Addr == ex_rdAddr);
      rs2_match  = id_useRs2 & (id_rs2Addr == ex_rdAddr);
      hz         = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rdAddr != 5'd0) &
                   id_valid & (rs1_match | rs2_match);
      // A flush discards the ID instruction, so it never needs to be held.
      pc_write   = ~hz | ex_flush;
      ifid_write = ~hz | ex_flush;
      ifid_flush = ex_flush;
   end

   // Pipeline register: reset, flush and hazard all produce a fully zeroed bubble.
   always_ff @(posedge clk) begin
      if (rst || ex_flush || hz) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_rs1Data <= '0;
         ex_rs2Data <= '0;
         ex_imm     <= '0;
         ex_rs1Addr <= '0;
         ex_rs2Addr <= '0;
         ex_rdAddr  <= '0;
         ex_ctrl    <= '0;
      end else begin
         ex_valid   <= id_valid;
         ex_pc      <= id_pc;
         ex_rs1Data <= id_rs1Data;
         ex_rs2Data <= id_rs2Data;
         ex_imm     <= id_imm;
         ex_rs1Addr <= id_rs1Addr;
         ex_rs2Addr <= id_rs2Addr;
         ex_rdAddr  <= id_rdAddr;
         // An invalid slot must never carry side-effecting control into EX.
         ex_ctrl    <= id_valid ? id_ctrl : '0;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Event counters; a stall masked by a flush is counted only as a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (hz && !ex_flush) stall_cnt_r <= stall_cnt_r + 32'd1;
         if (ex_flush)        flush_cnt_r <= flush_cnt_r + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: directed steps, combinational
// hazard outputs checked before each edge, registered ex_* fields checked
// after the edge against values queued when the step was driven.
module tb_id_ex_hazard_reg;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 10;
   localparam int W      = 1 + 4*XLEN + 15 + CTRL_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc, id_rs1Data, id_rs2Data, id_imm;
   logic [4:0]        id_rs1Addr, id_rs2Addr, id_rdAddr;
   logic              id_useRs1, id_useRs2;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_flush;
   logic              pc_write, ifid_write, ifid_flush;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_rs1Data, ex_rs2Data, ex_imm;
   logic [4:0]        ex_rs1Addr, ex_rs2Addr, ex_rdAddr;
   logic [CTRL_W-1:0] ex_ctrl;
`ifdef PERF_CNT_EN
   logic [31:0]       stall_cnt, flush_cnt;
`endif

   int compared   = 0;
   int mismatched = 0;
   int exp_stalls = 0;
   int exp_flushes = 0;
   logic [W-1:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   id_ex_hazard_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data), .id_imm(id_imm),
      .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr), .id_rdAddr(id_rdAddr),
      .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .id_ctrl(id_ctrl),
      .ex_flush(ex_flush), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1Data(ex_rs1Data), .ex_rs2Data(ex_rs2Data), .ex_imm(ex_imm),
      .ex_rs1Addr(ex_rs1Addr), .ex_rs2Addr(ex_rs2Addr), .ex_rdAddr(ex_rdAddr),
      .ex_ctrl(ex_ctrl)
`ifdef PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Driver: present one ID-stage instruction.
   task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] imm,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic [9:0] ctrl);
      id_valid = v; id_pc = pc; id_rs1Data = d1; id_rs2Data = d2; id_imm = imm;
      id_rs1Addr = a1; id_rs2Addr = a2; id_rdAddr = rd;
      id_useRs1 = u1; id_useRs2 = u2; id_ctrl = ctrl;
   endtask

   task automatic drive_random;
      drive_id(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
   endtask

   // One cycle: inputs already driven after a negedge. exp_stall is the
   // directed expectation of a load-use stall for this step.
   task automatic step(input string tag, input logic exp_stall, input bit chk_comb);
      logic [W-1:0] exp;
      logic [W-1:0] obs;
      logic exp_pcw;
      #1;
      exp_pcw = ~exp_stall | ex_flush;
      if (chk_comb) begin
         check({tag, ".pc_write"},   W'(pc_write),   W'(exp_pcw));
         check({tag, ".ifid_write"}, W'(ifid_write), W'(exp_pcw));
         check({tag, ".ifid_flush"}, W'(ifid_flush), W'(ex_flush));
      end
      if (rst || ex_flush || exp_stall)
         exp = '0;
      else
         exp = {id_valid, id_pc, id_rs1Data, id_rs2Data, id_imm,
                id_rs1Addr, id_rs2Addr, id_rdAddr, (id_valid ? id_ctrl : 10'd0)};
      exp_q.push_back(exp);
      if (rst) begin
         exp_stalls = 0; exp_flushes = 0;
      end else if (ex_flush) begin
         exp_flushes++;
      end else if (exp_stall) begin
         exp_stalls++;
      end
      @(posedge clk);
      #1;
      obs = {ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm,
             ex_rs1Addr, ex_rs2Addr, ex_rdAddr, ex_ctrl};
      if (exp_q.size() == 0) begin
         check({tag, ".queue_empty"}, W'(1), W'(0));
      end else begin
         check({tag, ".ex_regs"}, obs, exp_q.pop_front());
      end
      @(negedge clk);
   endtask

   localparam logic [9:0] C_LW  = 10'h01B;  // RegWrite|MemRead|MemtoReg|ALUSrc
   localparam logic [9:0] C_ADD = 10'h001;

   initial begin
      rst = 1'b1; ex_flush = 1'b0;
      drive_random();
      @(negedge clk);

      // Reset held two cycles with random ID inputs.
      drive_random();  step("reset0", 1'b0, 1'b0);
      drive_random();  step("reset1", 1'b0, 1'b0);
      rst = 1'b0;

      // Pass-through.
      drive_id(1, 32'h100, 32'hDEADBEEF, 32'h12345678, 32'h4, 5'd1, 5'd2, 5'd3, 1, 1, 10'h011);
      step("pass", 1'b0, 1'b1);

      // lw x5 enters EX; then add x6,x5,x7 stalls one cycle.
      drive_id(1, 32'h104, 32'h11, 32'h22, 32'h8, 5'd2, 5'd2, 5'd5, 1, 0, C_LW);
      step("lw_x5", 1'b0, 1'b1);
      drive_id(1, 32'h108, 32'h33, 32'h44, 32'h0, 5'd5, 5'd7, 5'd6, 1, 1, C_ADD);
      step("loaduse_stall", 1'b1, 1'b1);
      step("loaduse_release", 1'b0, 1'b1);

      // lw x0 followed by use of x0: no stall.
      drive_id(1, 32'h10C, 32'h0, 32'h0, 32'h10, 5'd1, 5'd0, 5'd0, 1, 0, C_LW);
      step("lw_x0", 1'b0, 1'b1);
      drive_id(1, 32'h110, 32'h0, 32'h55, 32'h0, 5'd0, 5'd0, 5'd8, 1, 1, C_ADD);
      step("use_x0", 1'b0, 1'b1);

      // lw x5 followed by unused rs2=x5: no stall.
      drive_id(1, 32'h114, 32'h66, 32'h0, 32'h14, 5'd1, 5'd0, 5'd5, 1, 0, C_LW);
      step("lw_x5_b", 1'b0, 1'b1);
      drive_id(1, 32'h118, 32'h77, 32'h88, 32'h0, 5'd9, 5'd5, 5'd10, 1, 0, C_ADD);
      step("unused_rs2", 1'b0, 1'b1);

      // lw x5 followed by a real rs2 use: stall.
      drive_id(1, 32'h11C, 32'h1, 32'h0, 32'h18, 5'd1, 5'd0, 5'd5, 1, 0, C_LW);
      step("lw_x5_c", 1'b0, 1'b1);
      drive_id(1, 32'h120, 32'h2, 32'h3, 32'h0, 5'd9, 5'd5, 5'd11, 1, 1, C_ADD);
      step("rs2_stall", 1'b1, 1'b1);
      step("rs2_release", 1'b0, 1'b1);

      // Hazard plus flush: flush wins, no stall, bubble.
      drive_id(1, 32'h124, 32'h4, 32'h0, 32'h1C, 5'd1, 5'd0, 5'd5, 1, 0, C_LW);
      step("lw_x5_d", 1'b0, 1'b1);
      drive_id(1, 32'h128, 32'h5, 32'h6, 32'h0, 5'd5, 5'd3, 5'd12, 1, 1, C_ADD);
      ex_flush = 1'b1;
      step("flush_vs_hz", 1'b0, 1'b1);
      ex_flush = 1'b0;
      drive_id(1, 32'h200, 32'h7, 32'h8, 32'h0, 5'd5, 5'd3, 5'd13, 1, 1, C_ADD);
      step("after_flush", 1'b0, 1'b1);

      // Invalid load: ctrl forced to 0, so its rd never causes a stall.
      drive_id(0, 32'h204, 32'h9, 32'hA, 32'h20, 5'd1, 5'd2, 5'd5, 1, 0, C_LW);
      step("invalid_lw", 1'b0, 1'b1);
      drive_id(1, 32'h208, 32'hB, 32'hC, 32'h0, 5'd5, 5'd5, 5'd14, 1, 1, C_ADD);
      step("after_invalid", 1'b0, 1'b1);

      // Valid load with an invalid ID consumer: no stall.
      drive_id(1, 32'h20C, 32'hD, 32'h0, 32'h24, 5'd1, 5'd0, 5'd5, 1, 0, C_LW);
      step("lw_x5_e", 1'b0, 1'b1);
      drive_id(0, 32'h210, 32'hE, 32'hF, 32'h0, 5'd5, 5'd5, 5'd15, 1, 1, C_ADD);
      step("invalid_consumer", 1'b0, 1'b1);

      // Plain flush with no hazard.
      drive_id(1, 32'h214, 32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd3, 1, 1, C_ADD);
      ex_flush = 1'b1;
      step("plain_flush", 1'b0, 1'b1);
      ex_flush = 1'b0;

      // Third load-use stall for the counters.
      drive_id(1, 32'h218, 32'h1, 32'h0, 32'h0, 5'd1, 5'd0, 5'd20, 1, 0, C_LW);
      step("lw_x20", 1'b0, 1'b1);
      drive_id(1, 32'h21C, 32'h2, 32'h3, 32'h0, 5'd20, 5'd0, 5'd21, 1, 0, C_ADD);
      step("stall3", 1'b1, 1'b1);
      step("stall3_release", 1'b0, 1'b1);

`ifdef PERF_CNT_EN
      check("stall_cnt", W'(stall_cnt), W'(exp_stalls));
      check("flush_cnt", W'(flush_cnt), W'(exp_flushes));
      // Wrap: preload the stall counter and take one more stall.
      dut.stall_cnt_r = 32'hFFFF_FFFF;
      drive_id(1, 32'h220, 32'h1, 32'h0, 32'h0, 5'd1, 5'd0, 5'd22, 1, 0, C_LW);
      step("lw_x22", 1'b0, 1'b1);
      drive_id(1, 32'h224, 32'h2, 32'h3, 32'h0, 5'd22, 5'd0, 5'd23, 1, 0, C_ADD);
      step("stall_wrap", 1'b1, 1'b1);
      check("stall_cnt_wrap", W'(stall_cnt), W'(0));
`endif

      check("queue_drained", W'(exp_q.size()), W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
